// File: rtl/perm_inverse_checker.sv
// perm_inverse_checker: serial checker for one packed permutation of N W-bit elements.
// The design scans one element per cycle and builds the inverse table. It reports
// duplicate, out-of-range and missing values, and holds the result until the
// downstream side takes it.
module perm_inverse_checker #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] seq_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N*W-1:0] inv_out,
    output logic           valid_perm,
    output logic           dup_err,
    output logic           range_err,
    output logic [N-1:0]   missing_mask,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic [W-1:0]   elem_reg [N];
    logic [N-1:0]   seen_reg, seen_next;
    logic [W-1:0]   inv_reg [N];
    logic [W-1:0]   inv_next [N];
    logic           dup_reg, dup_next;
    logic           rng_reg, rng_next;
    logic [W-1:0]   cur_v;
    logic           accept;
    logic           finish_scan;

    // Result registers are loaded once per scan, so they keep their value in IDLE.
    logic [W-1:0]   inv_out_reg [N];
    logic           valid_perm_reg;
    logic           dup_err_reg;
    logic           range_err_reg;
    logic [N-1:0]   missing_reg;
    logic           in_ready_reg;

    assign accept      = in_valid && in_ready_reg;
    assign finish_scan = (state_reg == SCAN) && (state_next == DONE);

    assign in_ready     = in_ready_reg;
    assign out_valid    = (state_reg == DONE);
    assign valid_perm   = valid_perm_reg;
    assign dup_err      = dup_err_reg;
    assign range_err    = range_err_reg;
    assign missing_mask = missing_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign inv_out[gi*W +: W] = inv_out_reg[gi];
        end
    endgenerate

    // Next-state logic: decides the FSM transition and applies the per-element scan update.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        seen_next  = seen_reg;
        dup_next   = dup_reg;
        rng_next   = rng_reg;
        for (int k = 0; k < N; k++) begin
            inv_next[k] = inv_reg[k];
        end
        cur_v = elem_reg[idx_reg];

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SCAN;
                    idx_next   = '0;
                    seen_next  = '0;
                    dup_next   = 1'b0;
                    rng_next   = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        inv_next[k] = '0;
                    end
                end
            end
            SCAN: begin
                if (32'(cur_v) >= N) begin
                    rng_next = 1'b1;
                end else if (seen_reg[cur_v]) begin
                    // The first occurrence of a value wins, so inv is left untouched.
                    dup_next = 1'b1;
                end else begin
                    seen_next[cur_v] = 1'b1;
                    inv_next[cur_v]  = W'(idx_reg);
                end
                if (idx_reg == IW'(N - 1)) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, scan bookkeeping and result registers. Reset drops any in-flight item.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            seen_reg       <= '0;
            dup_reg        <= 1'b0;
            rng_reg        <= 1'b0;
            in_ready_reg   <= 1'b0;
            valid_perm_reg <= 1'b0;
            dup_err_reg    <= 1'b0;
            range_err_reg  <= 1'b0;
            missing_reg    <= '0;
            for (int k = 0; k < N; k++) begin
                inv_reg[k]     <= '0;
                inv_out_reg[k] <= '0;
                elem_reg[k]    <= '0;
            end
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            seen_reg     <= seen_next;
            dup_reg      <= dup_next;
            rng_reg      <= rng_next;
            // The registered ready rises one cycle after reset release and right after a retire.
            in_ready_reg <= (state_next == IDLE);
            for (int k = 0; k < N; k++) begin
                inv_reg[k] <= inv_next[k];
                if (accept) begin
                    elem_reg[k] <= seq_in[k*W +: W];
                end
            end
            if (finish_scan) begin
                valid_perm_reg <= !dup_next && !rng_next && (&seen_next);
                dup_err_reg    <= dup_next;
                range_err_reg  <= rng_next;
                missing_reg    <= ~seen_next;
                for (int k = 0; k < N; k++) begin
                    inv_out_reg[k] <= inv_next[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_perm_inverse_checker.sv
// tb_perm_inverse_checker: directed and random checks of perm_inverse_checker,
// using a queue of expected results filled when each input is accepted.
module tb_perm_inverse_checker;

    localparam int N = 16;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] seq_in;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] inv_out;
    logic           valid_perm;
    logic           dup_err;
    logic           range_err;
    logic [N-1:0]   missing_mask;
    logic           out_valid;
    logic           out_ready;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N*W-1:0] inv;
        logic           vp;
        logic           dup;
        logic           rng;
        logic [N-1:0]   miss;
    } exp_t;

    exp_t exp_q[$];

    perm_inverse_checker #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .seq_in       (seq_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inv_out      (inv_out),
        .valid_perm   (valid_perm),
        .dup_err      (dup_err),
        .range_err    (range_err),
        .missing_mask (missing_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference result, computed from the input vector alone.
    function automatic exp_t model(input logic [N*W-1:0] s);
        exp_t e;
        logic [N-1:0] seen;
        logic [W-1:0] v;
        e.inv = '0;
        e.dup = 1'b0;
        e.rng = 1'b0;
        seen  = '0;
        for (int i = 0; i < N; i++) begin
            v = s[i*W +: W];
            if (int'(v) >= N) e.rng = 1'b1;
            else if (seen[v]) e.dup = 1'b1;
            else begin
                seen[v] = 1'b1;
                e.inv[int'(v)*W +: W] = W'(i);
            end
        end
        e.miss = ~seen;
        e.vp   = !e.dup && !e.rng && (&seen);
        return e;
    endfunction

    // Entered and left just after a negedge. Waits for ready, then drives one accept.
    task automatic send(input logic [N*W-1:0] s, input string tag);
        int b = 0;
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        seq_in   = s;
        in_valid = 1'b1;
        exp_q.push_back(model(s));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("txn %s: sent seq_in=%h", tag, s);
    endtask

    task automatic wait_result(input string tag);
        int lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(N));
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_inv_out"}, 64'(inv_out), 64'(e.inv));
            chk({tag, "_valid_perm"}, 64'(valid_perm), 64'(e.vp));
            chk({tag, "_dup_err"}, 64'(dup_err), 64'(e.dup));
            chk({tag, "_range_err"}, 64'(range_err), 64'(e.rng));
            chk({tag, "_missing"}, 64'(missing_mask), 64'(e.miss));
            $display("txn %s: inv_out=%h valid_perm=%0b dup=%0b miss=%h",
                     tag, inv_out, valid_perm, dup_err, missing_mask);
        end
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_retired_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_retired_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [N*W-1:0] ident;
        logic [N*W-1:0] rev;
        logic [N*W-1:0] dupv;
        logic [N*W-1:0] snap_inv;
        logic [N*W-1:0] comp;
        logic [N*W-1:0] rp;
        logic [N-1:0]   snap_miss;
        logic           snap_vp;
        int             arr [N];
        int             j;
        int             tmp;
        logic [W-1:0]   v;

        ident = 64'hFEDCBA9876543210;
        rev   = 64'h0123456789ABCDEF;
        dupv  = 64'hFEDCBA9876543200;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        seq_in    = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_inv_out", 64'(inv_out), 64'd0);
        chk("rst_missing", 64'(missing_mask), 64'd0);
        chk("rst_valid_perm", 64'(valid_perm), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Identity permutation
        send(ident, "identity");
        wait_result("identity");
        chk("identity_inv_const", 64'(inv_out), 64'(ident));
        chk("identity_vp_const", 64'(valid_perm), 64'd1);
        chk("identity_miss_const", 64'(missing_mask), 64'd0);
        compare_result("identity");
        retire("identity");

        // Reverse permutation
        send(rev, "reverse");
        wait_result("reverse");
        chk("reverse_inv_const", 64'(inv_out), 64'(rev));
        chk("reverse_dup_const", 64'(dup_err), 64'd0);
        compare_result("reverse");
        retire("reverse");

        // Duplicate value 0, value 1 missing
        send(dupv, "duplicate");
        wait_result("duplicate");
        chk("duplicate_vp_const", 64'(valid_perm), 64'd0);
        chk("duplicate_dup_const", 64'(dup_err), 64'd1);
        chk("duplicate_miss_const", 64'(missing_mask), 64'h0002);
        chk("duplicate_inv0_const", 64'(inv_out[3:0]), 64'd0);
        compare_result("duplicate");
        retire("duplicate");

        // Backpressure: hold the result for 5 cycles
        send(rev, "backpressure");
        wait_result("backpressure");
        snap_inv  = inv_out;
        snap_miss = missing_mask;
        snap_vp   = valid_perm;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_inv_stable", 64'(inv_out), 64'(snap_inv));
            chk("bp_miss_stable", 64'(missing_mask), 64'(snap_miss));
            chk("bp_vp_stable", 64'(valid_perm), 64'(snap_vp));
        end
        compare_result("backpressure");
        retire("backpressure");

        // Reset in the middle of a scan, at idx 7
        send(ident, "midreset");
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        void'(exp_q.pop_back());
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_inv_out", 64'(inv_out), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd0);
        chk("midreset_missing", 64'(missing_mask), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_rel_in_ready", 64'(in_ready), 64'd1);
        $display("txn midreset: scan aborted by reset");

        // 100 random permutations, as a generator would emit them
        for (int t = 0; t < 100; t++) begin
            for (int i = 0; i < N; i++) arr[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                j      = int'($urandom_range(i, 0));
                tmp    = arr[i];
                arr[i] = arr[j];
                arr[j] = tmp;
            end
            for (int i = 0; i < N; i++) rp[i*W +: W] = W'(arr[i]);
            send(rp, "random");
            wait_result("random");
            chk("random_vp", 64'(valid_perm), 64'd1);
            for (int i = 0; i < N; i++) begin
                v = rp[i*W +: W];
                comp[i*W +: W] = inv_out[int'(v)*W +: W];
            end
            chk("random_compose", 64'(comp), 64'(ident));
            compare_result("random");
            retire("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
